// File: rtl/dmem_port_arbiter.sv
// Purpose : shares one data-memory port between store-commit and load unit; stores win
//           by default, a starvation counter forces loads through after STARVE_LIMIT losses.
// Latency : stores write on the grant edge; load response / store error exactly 1 cycle after grant.
// Backpr. : st_ready/ld_ready are the combinational grant; the response path has no backpressure.
// Ports   : clk/reset (async, active-high); st_* store request + st_err pulse;
//           ld_* load request + ld_resp_* registered tagged response; mem_* datamem pins
//           (mem_read_data is a combinational read of mem_address).
module dmem_port_arbiter #(
  parameter int MEM_SIZE     = 1024,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [63:0]      st_addr,
  input  logic [63:0]      st_data,
  input  logic [3:0]       st_size,
  output logic             st_err,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [63:0]      ld_addr,
  input  logic [3:0]       ld_size,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic [63:0]      ld_resp_data,
  output logic             ld_resp_err,
  output logic [63:0]      mem_address,
  output logic             mem_write_enable,
  output logic             mem_read_enable,
  output logic [63:0]      mem_write_data,
  output logic [3:0]       mem_xfer_size,
  input  logic [63:0]      mem_read_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {ST_PRI = 1'b0, LD_PRI = 1'b1} pri_e;

  pri_e             state_q, state_d;
  logic [CNT_W-1:0] starv_cnt_q, starv_cnt_d;
  logic             resp_vld_q, resp_vld_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic [63:0]      resp_dat_q, resp_dat_d;
  logic             resp_err_q, resp_err_d;
  logic             st_err_q, st_err_d;

  logic             st_gnt, ld_gnt, st_ok, ld_ok;
  logic [63:0]      rd_masked;

  // Size must be 1/2/4/8, naturally aligned, and the last byte inside memory.
  // The end address is formed at 65 bits so a huge address cannot wrap into range.
  function automatic logic legal(input logic [63:0] a, input logic [3:0] s);
    logic        size_ok;
    logic [64:0] end_addr;
    size_ok  = (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
    end_addr = {1'b0, a} + {61'b0, s};
    return size_ok && ((a & {60'b0, s - 4'd1}) == 64'b0) && (end_addr <= 65'(MEM_SIZE));
  endfunction

  function automatic logic [63:0] size_mask(input logic [3:0] s);
    case (s)
      4'd1:    return 64'h0000_0000_0000_00FF;
      4'd2:    return 64'h0000_0000_0000_FFFF;
      4'd4:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  assign st_ok     = legal(st_addr, st_size);
  assign ld_ok     = legal(ld_addr, ld_size);
  assign rd_masked = mem_read_data & size_mask(ld_size);

  // A lone request always wins; under contention the FSM state picks the winner.
  assign st_gnt   = st_valid && (!ld_valid || (state_q == ST_PRI));
  assign ld_gnt   = ld_valid && (!st_valid || (state_q == LD_PRI));
  assign st_ready = st_gnt;
  assign ld_ready = ld_gnt;

  always_comb begin
    starv_cnt_d = starv_cnt_q;
    state_d     = state_q;
    if (ld_gnt) begin
      starv_cnt_d = '0;
    end else if (ld_valid && st_gnt && (starv_cnt_q != LIMIT)) begin
      starv_cnt_d = starv_cnt_q + 1'b1;
    end
    // Switch on the updated count so loads win on exactly the cycle after the
    // STARVE_LIMIT-th lost cycle.
    case (state_q)
      ST_PRI:  if (starv_cnt_d == LIMIT) state_d = LD_PRI;
      LD_PRI:  if (ld_gnt) state_d = ST_PRI;
      default: state_d = ST_PRI;
    endcase
  end

  always_comb begin
    mem_address      = 64'b0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = 64'b0;
    mem_xfer_size    = 4'd8;
    if (st_gnt && st_ok) begin
      mem_address      = st_addr;
      mem_write_enable = 1'b1;
      mem_write_data   = st_data;
      mem_xfer_size    = st_size;
    end else if (ld_gnt && ld_ok) begin
      mem_address     = ld_addr;
      mem_read_enable = 1'b1;
      mem_xfer_size   = ld_size;
    end
  end

  always_comb begin
    resp_vld_d = ld_gnt;
    resp_tag_d = resp_tag_q;
    resp_dat_d = resp_dat_q;
    resp_err_d = resp_err_q;
    st_err_d   = st_gnt && !st_ok;
    if (ld_gnt) begin
      resp_tag_d = ld_tag;
      resp_dat_d = ld_ok ? rd_masked : 64'b0;
      resp_err_d = !ld_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PRI;
      starv_cnt_q <= '0;
      resp_vld_q  <= 1'b0;
      resp_tag_q  <= '0;
      resp_dat_q  <= 64'b0;
      resp_err_q  <= 1'b0;
      st_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starv_cnt_q <= starv_cnt_d;
      resp_vld_q  <= resp_vld_d;
      resp_tag_q  <= resp_tag_d;
      resp_dat_q  <= resp_dat_d;
      resp_err_q  <= resp_err_d;
      st_err_q    <= st_err_d;
    end
  end

  assign ld_resp_valid = resp_vld_q;
  assign ld_resp_tag   = resp_tag_q;
  assign ld_resp_data  = resp_dat_q;
  assign ld_resp_err   = resp_err_q;
  assign st_err        = st_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : directed bench for dmem_port_arbiter with a byte-array data memory model.
// Latency : inputs change 1ns after posedge, comb outputs sampled 4ns later, registered ones 1ns after posedge.
// Backpr. : requests are held until granted, as the handshake requires.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, st_err;
  logic [63:0] st_addr, st_data;
  logic [3:0]  st_size;
  logic        ld_valid, ld_ready;
  logic [63:0] ld_addr;
  logic [3:0]  ld_size;
  logic [3:0]  ld_tag;
  logic        ld_resp_valid, ld_resp_err;
  logic [3:0]  ld_resp_tag;
  logic [63:0] ld_resp_data;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MEM_SIZE(1024), .TAG_W(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_err(st_err),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_tag(ld_tag), .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag),
    .ld_resp_data(ld_resp_data), .ld_resp_err(ld_resp_err),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
  );

  // Little-endian byte memory: synchronous write of mem_xfer_size bytes, combinational 8-byte read.
  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(mem_xfer_size)) mem[mem_address[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_read_data = 64'b0;
    for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = mem[mem_address[9:0] + 10'(i)];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic set_st(input logic v, input logic [63:0] a, input logic [63:0] d, input logic [3:0] s);
    st_valid = v; st_addr = a; st_data = d; st_size = s;
  endtask

  task automatic set_ld(input logic v, input logic [63:0] a, input logic [3:0] s, input logic [3:0] t);
    ld_valid = v; ld_addr = a; ld_size = s; ld_tag = t;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset = 1'b1;
    set_st(1'b0, 64'h0, 64'h0, 4'd8);
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    #1;
    chk("rst_resp_valid", 64'(ld_resp_valid), 64'd0);
    chk("rst_resp_tag",   64'(ld_resp_tag), 64'd0);
    chk("rst_resp_data",  ld_resp_data, 64'd0);
    chk("rst_st_err",     64'(st_err), 64'd0);
    chk("idle_xfer_size", 64'(mem_xfer_size), 64'd8);
    tick(); tick();
    reset = 1'b0;

    // 1. store 8B then load 8B tag 3
    set_st(1'b1, 64'h10, 64'h1122334455667788, 4'd8);
    mid();
    chk("t1_st_ready", 64'(st_ready), 64'd1);
    chk("t1_mem_we",   64'(mem_write_enable), 64'd1);
    chk("t1_mem_addr", mem_address, 64'h10);
    tick();
    set_st(1'b0, 64'h0, 64'h0, 4'd8);
    chk("t1_st_err", 64'(st_err), 64'd0);
    set_ld(1'b1, 64'h10, 4'd8, 4'd3);
    mid();
    chk("t1_ld_ready", 64'(ld_ready), 64'd1);
    chk("t1_mem_re",   64'(mem_read_enable), 64'd1);
    tick();
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    chk("t1_resp_valid", 64'(ld_resp_valid), 64'd1);
    chk("t1_resp_tag",   64'(ld_resp_tag), 64'd3);
    chk("t1_resp_data",  ld_resp_data, 64'h1122334455667788);
    chk("t1_resp_err",   64'(ld_resp_err), 64'd0);
    tick();
    chk("t1_resp_pulse", 64'(ld_resp_valid), 64'd0);

    // 2. sub-word load 2B @0x12
    set_ld(1'b1, 64'h12, 4'd2, 4'd5);
    tick();
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    chk("t2_resp_data", ld_resp_data, 64'h5566);
    chk("t2_resp_tag",  64'(ld_resp_tag), 64'd5);

    // 3. contention: expect 4 store grants then 1 load grant, repeating
    set_st(1'b1, 64'h100, 64'hA5A5, 4'd8);
    set_ld(1'b1, 64'h108, 4'd8, 4'd1);
    for (int i = 0; i < 10; i++) begin
      mid();
      chk($sformatf("t3_grant_%0d", i), {62'b0, st_ready, ld_ready},
          (i % 5 == 4) ? 64'd1 : 64'd2);
      tick();
    end
    set_st(1'b0, 64'h0, 64'h0, 4'd8);
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    tick();

    // 4. illegal requests
    set_ld(1'b1, 64'h6, 4'd4, 4'd7);
    mid();
    chk("t4_mis_ld_ready", 64'(ld_ready), 64'd1);
    chk("t4_mis_ld_re",    64'(mem_read_enable), 64'd0);
    tick();
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    chk("t4_mis_resp_valid", 64'(ld_resp_valid), 64'd1);
    chk("t4_mis_resp_err",   64'(ld_resp_err), 64'd1);
    chk("t4_mis_resp_data",  ld_resp_data, 64'd0);
    chk("t4_mis_resp_tag",   64'(ld_resp_tag), 64'd7);
    set_ld(1'b1, 64'h0, 4'd3, 4'd6);
    mid();
    chk("t4_size3_re", 64'(mem_read_enable), 64'd0);
    tick();
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    chk("t4_size3_err", 64'(ld_resp_err), 64'd1);
    set_st(1'b1, 64'h3F8, 64'h0102030405060708, 4'd8);
    mid();
    chk("t4_edge_st_we", 64'(mem_write_enable), 64'd1);
    tick();
    chk("t4_edge_st_err", 64'(st_err), 64'd0);
    set_st(1'b1, 64'h400, 64'hFFFF, 4'd8);
    mid();
    chk("t4_oob_st_ready", 64'(st_ready), 64'd1);
    chk("t4_oob_st_we",    64'(mem_write_enable), 64'd0);
    tick();
    set_st(1'b0, 64'h0, 64'h0, 4'd8);
    chk("t4_oob_st_err", 64'(st_err), 64'd1);
    tick();
    chk("t4_oob_st_err_pulse", 64'(st_err), 64'd0);

    // 5. same-address hazard: store first, load sees new data
    set_st(1'b1, 64'h20, 64'hDEADBEEF, 4'd4);
    set_ld(1'b1, 64'h20, 4'd4, 4'd9);
    mid();
    chk("t5_first_grant", {62'b0, st_ready, ld_ready}, 64'd2);
    tick();
    set_st(1'b0, 64'h0, 64'h0, 4'd8);
    mid();
    chk("t5_ld_ready", 64'(ld_ready), 64'd1);
    tick();
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    chk("t5_resp_data", ld_resp_data, 64'hDEADBEEF);
    chk("t5_resp_tag",  64'(ld_resp_tag), 64'd9);

    // 6. drive FSM to LD_PRI, then reset mid-cycle after a load grant
    set_st(1'b1, 64'h100, 64'h1, 4'd8);
    set_ld(1'b1, 64'h10, 4'd8, 4'd2);
    for (int i = 0; i < 4; i++) tick();
    mid();
    chk("t6_ld_pri_grant", {62'b0, st_ready, ld_ready}, 64'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_resp_valid", 64'(ld_resp_valid), 64'd0);
    chk("t6_rst_resp_tag",   64'(ld_resp_tag), 64'd0);
    chk("t6_rst_resp_data",  ld_resp_data, 64'd0);
    chk("t6_rst_resp_err",   64'(ld_resp_err), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk($sformatf("t6_post_grant_%0d", i), {62'b0, st_ready, ld_ready},
          (i == 4) ? 64'd1 : 64'd2);
      tick();
    end
    set_st(1'b0, 64'h0, 64'h0, 4'd8);
    set_ld(1'b0, 64'h0, 4'd8, 4'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
